burst_data: RTL and testbench

- Data-path responder for CAS commands issued by the CAS scheduler.
- Each CAS pulse (read or write) is timestamped and queued. The block then waits CL (read) or CWL (write) clocks and moves BL/2 double-beat cycles on the DQ bus.
- Pulses rw_done after each burst so the scheduler can apply read-to-write and write-to-read turnaround.
- Sits between the controller interface and the DDR4 device model; clocked on clock_t.

---
 rtl/burst_data.sv | 219 +++++++++++++++++++++
 tb/tb_burst_data.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/burst_data.sv
// CAS data-path responder: queues timestamped CAS commands, then drives write bursts and
// captures read bursts after CL/CWL. Optional DQS_PREAMBLE_EN adds a write DQS pre/postamble.
module burst_data #(
  parameter int unsigned DQ_W  = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TS_W  = 8
) (
  input  logic              clock_t,
  input  logic              reset,
  input  logic              cas_rdy,
  input  logic [1:0]        cas_rw,
  input  logic [4:0]        CL,
  input  logic [4:0]        CWL,
  input  logic [3:0]        BL,
  input  logic [2*DQ_W-1:0] wr_data,
  input  logic [2*DQ_W-1:0] dq_in,
  output logic              wr_req,
  output logic [2*DQ_W-1:0] dq_out,
  output logic              dq_oe,
  output logic              dqs_t,
  output logic              dqs_oe,
  output logic [2*DQ_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              rw_done,
  output logic              data_idle,
  output logic              q_full,
  output logic [1:0]        err
);

  // Any code other than WRITE is handled as a read.
  localparam logic [1:0]  RwWrite = 2'b10;
  localparam int unsigned AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {DIdle, DWait, DBurst, DDone} state_e;

  state_e          state_q;
  logic [2:0]      beat_q;
  logic            cur_wr_q;
  logic            dqs_oe_q;
  logic [1:0]      err_q;
  logic [TS_W-1:0] now_q;

  logic [DEPTH-1:0] qwr_q;
  logic [DEPTH-1:0] qb4_q;
  logic [TS_W-1:0]  qst_q [DEPTH];
  logic [AW-1:0]    wp_q;
  logic [AW-1:0]    rp_q;
  logic [AW:0]      cnt_q;

  logic            empty;
  logic            full;
  logic            push;
  logic            is_wr;
  logic            is_b4;
  logic [4:0]      lat;
  logic [4:0]      lat_c;
  logic [TS_W-1:0] start;
  logic            head_wr;
  logic [2:0]      head_beats;
  logic [TS_W-1:0] head_st;
  logic [TS_W-1:0] nxt;
  logic [TS_W-1:0] diff;
  logic            launch;
  logic            load;
  logic            burst_more;
  logic            burst_nxt;
  logic            in_burst;
  logic            in_rd_burst;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == (AW+1)'(DEPTH));
  assign push  = cas_rdy && !full;

  assign is_wr = (cas_rw == RwWrite);
  assign is_b4 = (BL == 4'd4);
  assign lat   = is_wr ? CWL : CL;
  assign lat_c = (lat == 5'd0) ? 5'd1 : lat;
  assign start = now_q + TS_W'(lat_c);

  assign head_wr    = qwr_q[rp_q];
  assign head_beats = qb4_q[rp_q] ? 3'd2 : 3'd4;
  assign head_st    = qst_q[rp_q];

  // Start stamps name the burst cycle itself, so the launch decision looks one cycle ahead.
  // A negative-half difference means the head is still in the future.
  assign nxt    = now_q + TS_W'(1);
  assign diff   = nxt - head_st;
  assign launch = !empty && !diff[TS_W-1];

  assign in_burst    = (state_q == DBurst);
  assign in_rd_burst = in_burst && !cur_wr_q;
  assign burst_more  = in_burst && (beat_q != 3'd1);

  always_comb begin
    load = 1'b0;
    case (state_q)
      DWait:   load = launch;
      DBurst:  load = (beat_q == 3'd1) && launch;
      default: load = 1'b0;
    endcase
  end

  assign burst_nxt = load || burst_more;
  assign wr_req    = (load && head_wr) || (burst_more && cur_wr_q);

  always_ff @(posedge clock_t or posedge reset) begin
    if (reset) begin
      now_q <= '0;
    end else begin
      now_q <= now_q + TS_W'(1);
    end
  end

  always_ff @(posedge clock_t or posedge reset) begin
    if (reset) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
      qwr_q <= '0;
      qb4_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        qst_q[i] <= '0;
      end
    end else begin
      if (push) begin
        qwr_q[wp_q] <= is_wr;
        qb4_q[wp_q] <= is_b4;
        qst_q[wp_q] <= start;
        wp_q        <= wp_q + AW'(1);
      end
      if (load) begin
        rp_q <= rp_q + AW'(1);
      end
      if (push && !load) begin
        cnt_q <= cnt_q + (AW+1)'(1);
      end else if (!push && load) begin
        cnt_q <= cnt_q - (AW+1)'(1);
      end
    end
  end

  always_ff @(posedge clock_t or posedge reset) begin
    if (reset) begin
      err_q <= 2'b00;
    end else begin
      err_q[0] <= err_q[0] | (cas_rdy && full);
      err_q[1] <= err_q[1] | (load && (diff != '0));
    end
  end

  always_ff @(posedge clock_t or posedge reset) begin
    if (reset) begin
      state_q  <= DIdle;
      beat_q   <= 3'd0;
      cur_wr_q <= 1'b0;
      rw_done  <= 1'b0;
      dq_oe    <= 1'b0;
      dqs_oe_q <= 1'b0;
      dqs_t    <= 1'b0;
      dq_out   <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rw_done <= 1'b0;
      case (state_q)
        DIdle: begin
          if (!empty) state_q <= DWait;
        end
        DWait: begin
          if (load) begin
            state_q  <= DBurst;
            beat_q   <= head_beats;
            cur_wr_q <= head_wr;
          end
        end
        DBurst: begin
          if (beat_q != 3'd1) begin
            beat_q <= beat_q - 3'd1;
          end else if (load) begin
            // Seamless chain: next burst follows the last beat with no gap.
            beat_q   <= head_beats;
            cur_wr_q <= head_wr;
          end else begin
            state_q <= DDone;
            rw_done <= 1'b1;
          end
        end
        DDone: begin
          state_q <= empty ? DIdle : DWait;
        end
        default: state_q <= DIdle;
      endcase

      dq_oe    <= wr_req;
      dq_out   <= wr_req ? wr_data : '0;
      dqs_t    <= burst_nxt && in_burst && !dqs_t;
      rd_valid <= in_rd_burst;
      if (in_rd_burst) rd_data <= dq_in;
`ifdef DQS_PREAMBLE_EN
      // Registered term also covers the one-cycle postamble after the last write beat.
      dqs_oe_q <= wr_req || (in_burst && cur_wr_q);
`else
      dqs_oe_q <= wr_req;
`endif
    end
  end

`ifdef DQS_PREAMBLE_EN
  // Preamble: the cycle before the first write beat, unless a write burst is already running.
  assign dqs_oe = dqs_oe_q || (wr_req && !(in_burst && cur_wr_q));
`else
  assign dqs_oe = dqs_oe_q;
`endif

  assign data_idle = (state_q == DIdle) && empty;
  assign q_full    = full;
  assign err       = err_q;

endmodule

// File: tb/tb_burst_data.sv
// Scoreboard bench for burst_data: stimulus pushes expected events, a negedge monitor pops them.
module tb_burst_data;

  localparam int         DQ_W = 8;
  localparam logic [1:0] RD   = 2'b01;
  localparam logic [1:0] WR   = 2'b10;

  logic              clock_t = 1'b0;
  logic              reset   = 1'b1;
  logic              cas_rdy = 1'b0;
  logic [1:0]        cas_rw  = 2'b00;
  logic [4:0]        cl      = 5'd0;
  logic [4:0]        cwl     = 5'd0;
  logic [3:0]        bl      = 4'd8;
  logic [2*DQ_W-1:0] wr_data;
  logic [2*DQ_W-1:0] dq_in;
  logic              wr_req;
  logic [2*DQ_W-1:0] dq_out;
  logic              dq_oe;
  logic              dqs_t;
  logic              dqs_oe;
  logic [2*DQ_W-1:0] rd_data;
  logic              rd_valid;
  logic              rw_done;
  logic              data_idle;
  logic              q_full;
  logic [1:0]        err;

  int cyc         = 0;
  int widx        = 0;
  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    int          t;
    logic [15:0] d;
    logic        s;
  } ev_t;

  ev_t exp_wr[$];
  ev_t exp_rd[$];
  int  exp_req[$];
  int  exp_done[$];

  burst_data #(.DQ_W(DQ_W), .DEPTH(4), .TS_W(8)) dut (
    .clock_t   (clock_t),
    .reset     (reset),
    .cas_rdy   (cas_rdy),
    .cas_rw    (cas_rw),
    .CL        (cl),
    .CWL       (cwl),
    .BL        (bl),
    .wr_data   (wr_data),
    .dq_in     (dq_in),
    .wr_req    (wr_req),
    .dq_out    (dq_out),
    .dq_oe     (dq_oe),
    .dqs_t     (dqs_t),
    .dqs_oe    (dqs_oe),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .rw_done   (rw_done),
    .data_idle (data_idle),
    .q_full    (q_full),
    .err       (err)
  );

  function automatic logic [15:0] wpat(input int i);
    return 16'hC000 + 16'(i * 259);
  endfunction

  function automatic logic [15:0] rpat(input int k);
    logic [7:0] b;
    b = k[7:0];
    return {b, ~b};
  endfunction

  assign wr_data = wpat(widx);
  assign dq_in   = rpat(cyc);

  always #5 clock_t = ~clock_t;
  always @(posedge clock_t) cyc <= cyc + 1;
  always @(posedge clock_t) if (wr_req) widx <= widx + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clock_t) begin
    ev_t e;
    int  t;
    if (!reset) begin
      if (wr_req) begin
        if (exp_req.size() == 0) chk("unexpected wr_req", 1, 0);
        else begin
          t = exp_req.pop_front();
          chk("wr_req cycle", cyc, t);
        end
      end
      if (dq_oe) begin
        if (exp_wr.size() == 0) chk("unexpected dq_oe", 1, 0);
        else begin
          e = exp_wr.pop_front();
          chk("dq_oe cycle", cyc, e.t);
          chk("dq_out", dq_out, e.d);
          chk("dqs_t in write", dqs_t, e.s);
          chk("dqs_oe in write", dqs_oe, 1);
        end
      end
      if (rd_valid) begin
        if (exp_rd.size() == 0) chk("unexpected rd_valid", 1, 0);
        else begin
          e = exp_rd.pop_front();
          chk("rd_valid cycle", cyc, e.t);
          chk("rd_data", rd_data, e.d);
        end
      end
      if (rw_done) begin
        if (exp_done.size() == 0) chk("unexpected rw_done", 1, 0);
        else begin
          t = exp_done.pop_front();
          chk("rw_done cycle", cyc, t);
        end
      end
    end
  end

  task automatic flush();
    exp_wr.delete();
    exp_rd.delete();
    exp_req.delete();
    exp_done.delete();
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    cas_rdy = 1'b0;
    flush();
    repeat (2) @(posedge clock_t);
    #1 reset = 1'b0;
  endtask

  // Called just after a rising edge; c is the cycle in which cas_rdy is high.
  task automatic issue(input logic [1:0] rw, input int l, input logic [3:0] b, output int c);
    cas_rw  = rw;
    cl      = (rw == WR) ? 5'(l + 5) : 5'(l);
    cwl     = (rw == WR) ? 5'(l) : 5'(l + 3);
    bl      = b;
    cas_rdy = 1'b1;
    c       = cyc;
    @(posedge clock_t);
    #1 cas_rdy = 1'b0;
  endtask

  task automatic at_cycle(input int t);
    do @(negedge clock_t); while (cyc < t);
    #1;
  endtask

  task automatic exp_write(input int c, input int l, input int beats, input int base);
    for (int i = 0; i < beats; i++) begin
      exp_req.push_back(c + l - 1 + i);
      exp_wr.push_back('{t: c + l + i, d: wpat(base + i), s: 1'(i & 1)});
    end
    exp_done.push_back(c + l + beats);
  endtask

  task automatic exp_read(input int s, input int beats);
    for (int i = 0; i < beats; i++) begin
      exp_rd.push_back('{t: s + i + 1, d: rpat(s + i), s: 1'b0});
    end
  endtask

  task automatic chk_pending(input string name);
    chk(name, exp_wr.size() + exp_rd.size() + exp_req.size() + exp_done.size(), 0);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, " wr_req"}, wr_req, 0);
    chk({tag, " dq_out"}, dq_out, 0);
    chk({tag, " dq_oe"}, dq_oe, 0);
    chk({tag, " dqs_t"}, dqs_t, 0);
    chk({tag, " dqs_oe"}, dqs_oe, 0);
    chk({tag, " rd_data"}, rd_data, 0);
    chk({tag, " rd_valid"}, rd_valid, 0);
    chk({tag, " rw_done"}, rw_done, 0);
    chk({tag, " data_idle"}, data_idle, 1);
    chk({tag, " q_full"}, q_full, 0);
    chk({tag, " err"}, err, 0);
  endtask

  initial begin
    int c0;
    int c1;
    int cx;
    int base;

    // Reset state
    repeat (2) @(posedge clock_t);
    #1 chk_quiet("reset");
    reset = 1'b0;

    // Single WRITE, CWL=9, BL=8
    @(posedge clock_t); #1;
    base = widx;
    issue(WR, 9, 4'd8, c0);
    exp_write(c0, 9, 4, base);
    at_cycle(c0 + 8);
`ifdef DQS_PREAMBLE_EN
    chk("preamble dqs_oe", dqs_oe, 1);
    chk("preamble dqs_t", dqs_t, 0);
`else
    chk("no preamble dqs_oe", dqs_oe, 0);
`endif
    at_cycle(c0 + 13);
    chk("data_idle during done", data_idle, 0);
`ifdef DQS_PREAMBLE_EN
    chk("postamble dqs_oe", dqs_oe, 1);
`else
    chk("no postamble dqs_oe", dqs_oe, 0);
`endif
    at_cycle(c0 + 14);
    chk("data_idle after write", data_idle, 1);
    chk("err after write", err, 0);
    chk_pending("write pending");

    // Single READ, CL=11, BL=4
    do_reset();
    issue(RD, 11, 4'd4, c0);
    exp_read(c0 + 11, 2);
    exp_done.push_back(c0 + 13);
    at_cycle(c0 + 16);
    chk("data_idle after read", data_idle, 1);
    chk_pending("read bl4 pending");

    // Two READs 4 cycles apart chain seamlessly
    do_reset();
    issue(RD, 11, 4'd8, c0);
    repeat (3) @(posedge clock_t);
    #1 issue(RD, 11, 4'd8, c1);
    exp_read(c0 + 11, 4);
    exp_read(c1 + 11, 4);
    exp_done.push_back(c1 + 15);
    at_cycle(c0 + 22);
    chk("err after chain", err, 0);
    chk_pending("chain pending");

    // Two READs 1 cycle apart: collision, second starts right after first
    do_reset();
    issue(RD, 11, 4'd8, c0);
    issue(RD, 11, 4'd8, c1);
    exp_read(c0 + 11, 4);
    exp_read(c0 + 15, 4);
    exp_done.push_back(c0 + 19);
    at_cycle(c0 + 22);
    chk("err collision", err, 2'b10);
    chk_pending("collision pending");

    // Five back-to-back CAS into a 4-deep queue
    do_reset();
    issue(RD, 20, 4'd8, c0);
    for (int i = 0; i < 4; i++) issue(RD, 20, 4'd8, cx);
    exp_read(c0 + 20, 16);
    exp_done.push_back(c0 + 36);
    at_cycle(c0 + 5);
    chk("err overflow", err, 2'b01);
    chk("q_full", q_full, 1);
    at_cycle(c0 + 40);
    chk("err overflow+collision", err, 2'b11);
    chk("q_full drained", q_full, 0);
    chk("data_idle after overflow", data_idle, 1);
    chk_pending("overflow pending");

    // Reset in the middle of a write burst
    do_reset();
    base = widx;
    issue(WR, 9, 4'd8, c0);
    exp_write(c0, 9, 4, base);
    at_cycle(c0 + 10);
    chk("dq_oe before abort", dq_oe, 1);
    reset = 1'b1;
    flush();
    #1 chk_quiet("async reset");
    repeat (2) @(posedge clock_t);
    #1 reset = 1'b0;
    at_cycle(c0 + 22);
    chk_pending("abort pending");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
